// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD registered read ports, two write ports with
// write-first bypass, optional hardwired zero entry, and a per-register pending scoreboard.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we0,
    input  logic [ADDR_W-1:0]     waddr0,
    input  logic [XLEN-1:0]       wdata0,
    input  logic                  we1,
    input  logic [ADDR_W-1:0]     waddr1,
    input  logic [XLEN-1:0]       wdata1,
    input  logic                  alloc_en,
    input  logic [ADDR_W-1:0]     alloc_addr,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*XLEN-1:0]   rdata,
    output logic [NRD-1:0]        rbusy,
    output logic [DEPTH-1:0]      pending
);

    logic [XLEN-1:0]  mem [DEPTH];
    logic             w0_ok, w1_ok, alloc_ok;
    logic [DEPTH-1:0] clr_mask, set_mask, pend_wc;

    // An address is writable/readable only if in range and not the hardwired zero entry.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        int unsigned ai;
        ai = {{(32-ADDR_W){1'b0}}, a};
        return (ai < DEPTH) && !((ZERO_REG != 0) && (ai == 0));
    endfunction

    assign w0_ok    = we0 && addr_ok(waddr0);
    assign w1_ok    = we1 && addr_ok(waddr1);
    assign alloc_ok = alloc_en && addr_ok(alloc_addr);

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (w0_ok)    clr_mask[waddr0]     = 1'b1;
        if (w1_ok)    clr_mask[waddr1]     = 1'b1;
        if (alloc_ok) set_mask[alloc_addr] = 1'b1;
    end

    // Reads observe the write clear but not the same-cycle alloc.
    assign pend_wc = pending & ~clr_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem     <= '{default: '0};
            pending <= '0;
        end else begin
            if (w0_ok) mem[waddr0] <= wdata0;
            if (w1_ok) mem[waddr1] <= wdata1;
            pending <= pend_wc | set_mask;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [XLEN-1:0]   d, q;
        logic              b, bq;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        // Port 1 write is checked first so it wins the bypass when both ports hit.
        always_comb begin
            d = '0;
            b = 1'b0;
            if (!addr_ok(ra)) begin
                d = '0;
                b = 1'b0;
            end else if (w1_ok && (waddr1 == ra)) begin
                d = wdata1;
            end else if (w0_ok && (waddr0 == ra)) begin
                d = wdata0;
            end else begin
                d = mem[ra];
                b = pend_wc[ra];
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                q  <= '0;
                bq <= 1'b0;
            end else if (rd_en[k]) begin
                q  <= d;
                bq <= b;
            end
        end

        assign rdata[k*XLEN +: XLEN] = q;
        assign rbusy[k]              = bq;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed spec scenarios followed by random traffic,
// all compared against an array-based reference model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        we0, we1, alloc_en;
    logic [4:0]  waddr0, waddr1, alloc_addr;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  rd_en;
    logic [9:0]  raddr;
    logic [63:0] rdata;
    logic [1:0]  rbusy;
    logic [31:0] pending;

    int errors = 0;
    int checks = 0;

    logic [31:0] m_mem [32];
    logic [31:0] m_pend;
    logic [63:0] m_rdata;
    logic [1:0]  m_rbusy;

    regfile_mp #(.XLEN(32), .DEPTH(32), .ADDR_W(5), .NRD(2), .ZERO_REG(1)) dut (
        .clk(clk), .reset(reset),
        .we0(we0), .waddr0(waddr0), .wdata0(wdata0),
        .we1(we1), .waddr1(waddr1), .wdata1(wdata1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr),
        .rd_en(rd_en), .raddr(raddr),
        .rdata(rdata), .rbusy(rbusy), .pending(pending)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Spec-level read rule: zero entry -> 0; a write to the same address is returned
    // (load port first) with busy 0; otherwise stored value and pre-alloc pending bit.
    function automatic logic [32:0] model_read(input logic [4:0] a);
        if (a == 5'd0)                return 33'd0;
        if (we1 && waddr1 == a)       return {1'b0, wdata1};
        if (we0 && waddr0 == a)       return {1'b0, wdata0};
        return {m_pend[a], m_mem[a]};
    endfunction

    task automatic model_step();
        if (reset) begin
            foreach (m_mem[i]) m_mem[i] = '0;
            m_pend  = '0;
            m_rdata = '0;
            m_rbusy = '0;
            return;
        end
        if (rd_en[0]) {m_rbusy[0], m_rdata[31:0]}  = model_read(raddr[4:0]);
        if (rd_en[1]) {m_rbusy[1], m_rdata[63:32]} = model_read(raddr[9:5]);
        if (we0 && waddr0 != 5'd0) begin m_mem[waddr0] = wdata0; m_pend[waddr0] = 1'b0; end
        if (we1 && waddr1 != 5'd0) begin m_mem[waddr1] = wdata1; m_pend[waddr1] = 1'b0; end
        if (alloc_en && alloc_addr != 5'd0) m_pend[alloc_addr] = 1'b1;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check("rdata",   rdata,           m_rdata);
        check("rbusy",   64'(rbusy),      64'(m_rbusy));
        check("pending", 64'(pending),    64'(m_pend));
    endtask

    task automatic idle();
        reset = 1'b0; we0 = 1'b0; we1 = 1'b0; alloc_en = 1'b0; rd_en = 2'b00;
        waddr0 = '0; waddr1 = '0; alloc_addr = '0; wdata0 = '0; wdata1 = '0; raddr = '0;
    endtask

    initial begin
        idle();
        // 1: reset, then read entries 0..3 on both ports
        reset = 1'b1;
        step();
        check("reset_pending", 64'(pending), 64'd0);
        idle(); rd_en = 2'b11; raddr = {5'd3, 5'd0}; step();
        check("t1_rdata_a", rdata, 64'd0);
        raddr = {5'd2, 5'd1}; step();
        check("t1_rdata_b", rdata, 64'd0);
        check("t1_rbusy", 64'(rbusy), 64'd0);

        // 2: write then read back
        idle(); we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF; step();
        idle(); rd_en = 2'b01; raddr[4:0] = 5'd5; step();
        check("t2_rdata0", 64'(rdata[31:0]), 64'hDEADBEEF);

        // 3: dual write same address with same-cycle bypass read on port 1
        idle(); we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h1111;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h2222;
        rd_en = 2'b10; raddr[9:5] = 5'd7; step();
        check("t3_bypass", 64'(rdata[63:32]), 64'h2222);
        idle(); rd_en = 2'b01; raddr[4:0] = 5'd7; step();
        check("t3_stored", 64'(rdata[31:0]), 64'h2222);

        // 4: scoreboard set by alloc, cleared by write with bypass
        idle(); alloc_en = 1'b1; alloc_addr = 5'd9; step();
        idle(); rd_en = 2'b01; raddr[4:0] = 5'd9; step();
        check("t4_rbusy", 64'(rbusy[0]), 64'd1);
        check("t4_pend9", 64'(pending[9]), 64'd1);
        idle(); we1 = 1'b1; waddr1 = 5'd9; wdata1 = 32'h55; rd_en = 2'b01; raddr[4:0] = 5'd9; step();
        check("t4_rdata", 64'(rdata[31:0]), 64'h55);
        check("t4_rbusy_clr", 64'(rbusy[0]), 64'd0);
        check("t4_pend9_clr", 64'(pending[9]), 64'd0);

        // 5: zero register ignores writes and alloc
        idle(); we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF; alloc_en = 1'b1; alloc_addr = 5'd0; step();
        idle(); rd_en = 2'b01; raddr[4:0] = 5'd0; step();
        check("t5_rdata", 64'(rdata[31:0]), 64'd0);
        check("t5_pend0", 64'(pending[0]), 64'd0);

        // 6: alloc+write same cycle keeps pending; reset overrides everything
        idle(); alloc_en = 1'b1; alloc_addr = 5'd3; we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'hABCD; step();
        check("t6_pend3", 64'(pending[3]), 64'd1);
        reset = 1'b1; step();
        check("t6_pend_rst", 64'(pending), 64'd0);
        idle(); rd_en = 2'b01; raddr[4:0] = 5'd3; step();
        check("t6_rdata3", 64'(rdata[31:0]), 64'd0);

        // Random traffic over a narrow address range to force collisions
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 63) == 0);
            we0        = $urandom_range(0, 1) == 1;
            we1        = $urandom_range(0, 2) == 0;
            alloc_en   = $urandom_range(0, 1) == 1;
            waddr0     = 5'($urandom_range(0, 11));
            waddr1     = 5'($urandom_range(0, 11));
            alloc_addr = 5'($urandom_range(0, 11));
            wdata0     = $urandom;
            wdata1     = $urandom;
            rd_en      = 2'($urandom_range(0, 3));
            raddr      = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
